// File: rtl/cordic_tanh_act_if.sv
// Operand/result handshake bundle for cordic_tanh_act.
// master = upstream MAC / downstream consumer side, slave = activation stage.
interface cordic_tanh_act_if #(
  parameter int IN_W = 4,
  parameter int W    = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic            sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, sat
  );
endinterface

// File: rtl/cordic_tanh_act.sv
// Iterative CORDIC tanh: hyperbolic rotation (sinh, cosh) then linear vectoring (y/x).
// Define ACT_SIGMOID_EN to compute sigmoid(x) = 0.5 + 0.5*tanh(x/2) instead.
module cordic_tanh_act #(
  parameter int IN_W = 4,
  parameter int IN_Q = 0,
  parameter int W    = 16,
  parameter int F    = 12,
  parameter int ITER = 12
) (
  input logic              clk,
  input logic              reset,
  cordic_tanh_act_if.slave bus
);

  localparam int CW = $clog2(ITER + 2);
  localparam logic signed [W-1:0] ONE = W'(1 << F);

  typedef enum logic [2:0] {IDLE, LOAD, HROT, LDIV, DONE} state_t;

  state_t                 state;
  logic signed [IN_W-1:0] acc;
  logic signed [W-1:0]    x_r, y_r, z_r;
  logic [CW-1:0]          i;
  logic                   rep;
  logic                   out_valid, sat;
  logic signed [W-1:0]    out_data;

  logic signed [W-1:0] x_sh, y_sh, x_h, y_h, z_h, y_l, z_l, res;
  logic signed [W-1:0] x_in, x_pre, x_clamped;
  logic                clamp_hit;

  // atanh(2^-k) held at 16 fractional bits, truncated down to F bits (F <= 16)
  function automatic logic signed [W-1:0] atanh_rom(input logic [CW-1:0] k);
    logic [31:0] q16;
    case (int'(k))
      1:       q16 = 32'd35999;
      2:       q16 = 32'd16738;
      3:       q16 = 32'd8235;
      4:       q16 = 32'd4101;
      5:       q16 = 32'd2048;
      6:       q16 = 32'd1024;
      7:       q16 = 32'd512;
      8:       q16 = 32'd256;
      9:       q16 = 32'd128;
      10:      q16 = 32'd64;
      11:      q16 = 32'd32;
      12:      q16 = 32'd16;
      default: q16 = '0;
    endcase
    return W'(q16 >> (16 - F));
  endfunction

  always_comb begin
    x_sh = x_r >>> i;
    y_sh = y_r >>> i;
    // Rotation: drive z toward zero, z >= 0 counts as positive
    x_h  = !z_r[W-1] ? x_r + y_sh : x_r - y_sh;
    y_h  = !z_r[W-1] ? y_r + x_sh : y_r - x_sh;
    z_h  = !z_r[W-1] ? z_r - atanh_rom(i) : z_r + atanh_rom(i);
    // Vectoring: drive y toward zero, z accumulates y/x
    y_l  = !y_r[W-1] ? y_r - x_sh : y_r + x_sh;
    z_l  = !y_r[W-1] ? z_r + (ONE >>> i) : z_r - (ONE >>> i);

    x_in = {{(W-IN_W){acc[IN_W-1]}}, acc};
    x_in = x_in <<< (F - IN_Q);
`ifdef ACT_SIGMOID_EN
    x_pre = x_in >>> 1;
    res   = (z_l >>> 1) + (ONE >>> 1);
`else
    x_pre = x_in;
    res   = z_l;
`endif
    clamp_hit = (x_pre > ONE) || (x_pre < -ONE);
    if (x_pre > ONE)       x_clamped = ONE;
    else if (x_pre < -ONE) x_clamped = -ONE;
    else                   x_clamped = x_pre;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      i         <= '0;
      rep       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sat       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          acc   <= bus.in_data;
          state <= LOAD;
        end
        LOAD: begin
          x_r   <= ONE;
          y_r   <= '0;
          z_r   <= x_clamped;
          sat   <= clamp_hit;
          i     <= CW'(1);
          rep   <= 1'b0;
          state <= HROT;
        end
        HROT: begin
          x_r <= x_h;
          y_r <= y_h;
          z_r <= z_h;
          // Index 4 runs twice so the hyperbolic sequence converges
          if (i == CW'(4) && !rep) begin
            rep <= 1'b1;
          end else if (i == CW'(ITER)) begin
            z_r   <= '0;
            i     <= '0;
            state <= LDIV;
          end else begin
            i <= i + CW'(1);
          end
        end
        LDIV: begin
          y_r <= y_l;
          z_r <= z_l;
          if (i == CW'(ITER - 1)) begin
            out_data  <= res;
            out_valid <= 1'b1;
            i         <= '0;
            state     <= DONE;
          end else begin
            i <= i + CW'(1);
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.sat       = sat;

endmodule
